a1_stepper: RTL

A1 pixel-pointer stepper for the blitter address path. On a start command it walks the A1 pointer through an inner × outer loop, emitting one pixel address per handshake. Each pixel carries a clip flag from the A1 window test, and the block signals completion at the end. It is the producer of the A1 x/y pointer that the window comparator consumes; the same window test is applied internally to every emitted pixel.

---
 rtl/a1_pkg.sv | 14 +
 rtl/a1_win_check.sv | 17 +
 rtl/a1_stepper.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/a1_pkg.sv
// Shared types and widths for the A1 pixel-pointer stepper.
package a1_pkg;

    localparam int A1_PTR_W = 16;
    localparam int A1_WIN_W = 15;

    typedef enum logic [1:0] {
        IDLE,
        INNER,
        OUTER,
        DONE
    } a1_state_e;

endpackage

// File: rtl/a1_win_check.sv
// Combinational window test: negative or beyond-size coordinates are outside.
module a1_win_check
    import a1_pkg::*;
(
    input  logic [A1_PTR_W-1:0] x_i,
    input  logic [A1_PTR_W-1:0] y_i,
    input  logic [A1_WIN_W-1:0] win_x_i,
    input  logic [A1_WIN_W-1:0] win_y_i,
    output logic                outside_o
);

    assign outside_o = x_i[A1_PTR_W-1]
                     | (x_i[A1_WIN_W-1:0] >= win_x_i)
                     | y_i[A1_PTR_W-1]
                     | (y_i[A1_WIN_W-1:0] >= win_y_i);

endmodule

// File: rtl/a1_stepper.sv
// A1 pointer stepper: walks an inner x outer pixel loop, one address per handshake.
module a1_stepper
    import a1_pkg::*;
(
    input  logic                sys_clk,
    input  logic                resetl,
    input  logic                start,
    input  logic                abort,
    input  logic [A1_PTR_W-1:0] a1_x_init,
    input  logic [A1_PTR_W-1:0] a1_y_init,
    input  logic [A1_PTR_W-1:0] a1_inc_x,
    input  logic [A1_PTR_W-1:0] a1_inc_y,
    input  logic [A1_PTR_W-1:0] a1_step_x,
    input  logic [A1_PTR_W-1:0] a1_step_y,
    input  logic [A1_PTR_W-1:0] inner_cnt,
    input  logic [A1_PTR_W-1:0] outer_cnt,
    input  logic [A1_WIN_W-1:0] a1_win_x,
    input  logic [A1_WIN_W-1:0] a1_win_y,
    input  logic                pix_ready,
    output logic                pix_valid,
    output logic [A1_PTR_W-1:0] pix_x,
    output logic [A1_PTR_W-1:0] pix_y,
    output logic                pix_outside,
    output logic                busy,
    output logic                done
);

    a1_state_e           state_q, state_d;
    logic [A1_PTR_W-1:0] x_q, x_d, y_q, y_d;
    logic [A1_PTR_W-1:0] inc_x_q, inc_x_d, inc_y_q, inc_y_d;
    logic [A1_PTR_W-1:0] step_x_q, step_x_d, step_y_q, step_y_d;
    logic [A1_PTR_W-1:0] inner_cnt_q, inner_cnt_d;
    logic [A1_PTR_W-1:0] inner_rem_q, inner_rem_d;
    logic [A1_PTR_W-1:0] outer_rem_q, outer_rem_d;
    logic [A1_WIN_W-1:0] win_x_q, win_x_d, win_y_q, win_y_d;
    logic                outside;

    a1_win_check u_win (
        .x_i       (x_q),
        .y_i       (y_q),
        .win_x_i   (win_x_q),
        .win_y_i   (win_y_q),
        .outside_o (outside)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        inc_x_d     = inc_x_q;
        inc_y_d     = inc_y_q;
        step_x_d    = step_x_q;
        step_y_d    = step_y_q;
        inner_cnt_d = inner_cnt_q;
        inner_rem_d = inner_rem_q;
        outer_rem_d = outer_rem_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        x_d         = a1_x_init;
                        y_d         = a1_y_init;
                        inc_x_d     = a1_inc_x;
                        inc_y_d     = a1_inc_y;
                        step_x_d    = a1_step_x;
                        step_y_d    = a1_step_y;
                        inner_cnt_d = inner_cnt;
                        inner_rem_d = inner_cnt;
                        outer_rem_d = outer_cnt;
                        win_x_d     = a1_win_x;
                        win_y_d     = a1_win_y;
                        if (inner_cnt == '0 || outer_cnt == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = INNER;
                        end
                    end
                end
                INNER: begin
                    if (pix_ready) begin
                        if (inner_rem_q > 16'd1) begin
                            x_d         = x_q + inc_x_q;
                            y_d         = y_q + inc_y_q;
                            inner_rem_d = inner_rem_q - 16'd1;
                        end else if (outer_rem_q > 16'd1) begin
                            state_d = OUTER;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                // Line step is applied to the last pixel of the finished line.
                OUTER: begin
                    x_d         = x_q + step_x_q;
                    y_d         = y_q + step_y_q;
                    inner_rem_d = inner_cnt_q;
                    outer_rem_d = outer_rem_q - 16'd1;
                    state_d     = INNER;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            inc_x_q     <= '0;
            inc_y_q     <= '0;
            step_x_q    <= '0;
            step_y_q    <= '0;
            inner_cnt_q <= '0;
            inner_rem_q <= '0;
            outer_rem_q <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            inc_x_q     <= inc_x_d;
            inc_y_q     <= inc_y_d;
            step_x_q    <= step_x_d;
            step_y_q    <= step_y_d;
            inner_cnt_q <= inner_cnt_d;
            inner_rem_q <= inner_rem_d;
            outer_rem_q <= outer_rem_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
        end
    end

    // Flag is qualified by valid so an idle block with a zero window reads 0.
    assign pix_valid   = (state_q == INNER);
    assign pix_outside = outside & pix_valid;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule
